// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side framer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: framer FSM state enum, default start-of-frame marker,
// and the checksum fold used by the running XOR accumulator.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CSUM    = 2'd2,
      DROP    = 2'd3
   } state_e;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   // Widest data path the fold supports; callers zero-extend and truncate.
   localparam int CSUM_MAX_W = 64;

   function automatic logic [CSUM_MAX_W-1:0] csum_fold(
      input logic [CSUM_MAX_W-1:0] acc,
      input logic [CSUM_MAX_W-1:0] din
   );
      return acc ^ din;
   endfunction

endpackage

// File: rtl/fifo_frame_csum.sv
// Running XOR checksum accumulator with synchronous clear and inverted readout.
// Latency: folded value visible the cycle after en; readout is combinational.
// Backpressure: none; the caller only pulses en on accepted beats.
//
// Ports:
//   wr_clk, wr_rst : clock, asynchronous active-high reset
//   clr            : zero the accumulator (wins over en)
//   en             : fold din into the accumulator
//   inv            : present the complemented checksum on csum
//   din            : data beat to fold
//   csum           : current checksum (optionally inverted)
module fifo_frame_csum
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             wr_clk,
   input  logic             wr_rst,
   input  logic             clr,
   input  logic             en,
   input  logic             inv,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] csum
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = WIDTH'(csum_fold(CSUM_MAX_W'(acc_q), CSUM_MAX_W'(din)));
      end
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign csum = inv ? ~acc_q : acc_q;

endmodule

// File: rtl/fifo_wr_framer.sv
// Frames an upstream byte stream as SOF, payload, XOR checksum into the async FIFO write port.
// Latency: zero; wr_en/wr_data/in_ready are combinational from state, in_valid and full.
// Backpressure: full stalls the frame in place with no write; in DROP upstream is drained regardless of full.
//
// Ports:
//   wr_clk, wr_rst        : write-domain clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake, beat taken when both high
//   in_data/in_last       : payload beat and end-of-packet marker
//   full                  : FIFO full flag
//   wr_en/wr_data         : FIFO write port
//   frame_cnt             : completed frames, wraps at 2^CNT_W
//   err_overlen           : one-cycle pulse when a packet is truncated at MAX_LEN beats
module fifo_wr_framer
   import fifo_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               MAX_LEN = 64,
   parameter logic [WIDTH-1:0] SOF     = WIDTH'(SOF_DEFAULT),
   parameter int               CNT_W   = 16
) (
   input  logic             wr_clk,
   input  logic             wr_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             full,
   output logic             wr_en,
   output logic [WIDTH-1:0] wr_data,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             err_overlen
);

   localparam int               LEN_W   = $clog2(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN - 1);

   state_e           state_q,       state_d;
   logic [LEN_W-1:0] len_q,         len_d;
   logic             trunc_q,       trunc_d;
   logic [CNT_W-1:0] frame_cnt_q,   frame_cnt_d;
   logic             err_overlen_q, err_overlen_d;

   logic             wr_en_c;
   logic             in_ready_c;
   logic [WIDTH-1:0] wr_data_c;
   logic             csum_clr;
   logic             csum_en;
   logic [WIDTH-1:0] csum_out;

   fifo_frame_csum #(
      .WIDTH (WIDTH)
   ) u_csum (
      .wr_clk (wr_clk),
      .wr_rst (wr_rst),
      .clr    (csum_clr),
      .en     (csum_en),
      .inv    (trunc_q),
      .din    (in_data),
      .csum   (csum_out)
   );

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      trunc_d       = trunc_q;
      frame_cnt_d   = frame_cnt_q;
      err_overlen_d = 1'b0;
      wr_en_c       = 1'b0;
      in_ready_c    = 1'b0;
      wr_data_c     = SOF;
      csum_clr      = 1'b0;
      csum_en       = 1'b0;

      case (state_q)
         IDLE: begin
            // The SOF write is triggered by the first beat being offered,
            // but that beat itself is only taken once in PAYLOAD.
            wr_data_c = SOF;
            wr_en_c   = in_valid && !full;
            if (wr_en_c) begin
               state_d  = PAYLOAD;
               csum_clr = 1'b1;
               len_d    = '0;
               trunc_d  = 1'b0;
            end
         end

         PAYLOAD: begin
            in_ready_c = !full;
            wr_en_c    = in_valid && !full;
            wr_data_c  = in_data;
            if (wr_en_c) begin
               csum_en = 1'b1;
               // Saturate so len never leaves the 0..MAX_LEN-1 range.
               if (len_q != LEN_MAX) begin
                  len_d = len_q + LEN_W'(1);
               end
               if (in_last) begin
                  state_d = CSUM;
               end else if (len_q == LEN_MAX) begin
                  // MAX_LEN-th beat without last: close the frame early
                  // and discard the rest of the packet afterwards.
                  state_d       = CSUM;
                  trunc_d       = 1'b1;
                  err_overlen_d = 1'b1;
               end
            end
         end

         CSUM: begin
            wr_data_c = csum_out;
            wr_en_c   = !full;
            if (wr_en_c) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               state_d     = trunc_q ? DROP : IDLE;
               trunc_d     = 1'b0;
            end
         end

         DROP: begin
            // Nothing reaches the FIFO here, so full is irrelevant.
            in_ready_c = 1'b1;
            if (in_valid && in_last) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_q       <= IDLE;
         len_q         <= '0;
         trunc_q       <= 1'b0;
         frame_cnt_q   <= '0;
         err_overlen_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         trunc_q       <= trunc_d;
         frame_cnt_q   <= frame_cnt_d;
         err_overlen_q <= err_overlen_d;
      end
   end

   // IDLE decodes wr_en from in_valid, so gate it while reset is held.
   assign wr_en       = wr_en_c && !wr_rst;
   assign in_ready    = in_ready_c;
   assign wr_data     = wr_data_c;
   assign frame_cnt   = frame_cnt_q;
   assign err_overlen = err_overlen_q;

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Self-checking bench for fifo_wr_framer with MAX_LEN = 4 and CNT_W = 4.
module tb_fifo_wr_framer;

   localparam int MAXL = 4;

   logic       wr_clk = 1'b0;
   logic       wr_rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic       full;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [3:0] frame_cnt;
   logic       err_overlen;

   always #5 wr_clk = ~wr_clk;

   fifo_wr_framer #(
      .WIDTH   (8),
      .MAX_LEN (MAXL),
      .SOF     (8'hA5),
      .CNT_W   (4)
   ) dut (
      .wr_clk      (wr_clk),
      .wr_rst      (wr_rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .full        (full),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .frame_cnt   (frame_cnt),
      .err_overlen (err_overlen)
   );

   int         checks   = 0;
   int         errors   = 0;
   int         wr_total = 0;
   int         err_seen = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      int          n;
      logic [47:0] d;          // beat i in d[8*i +: 8]
      logic [7:0]  exp_csum;
      bit          exp_trunc;
      bit          stall;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every FIFO write is popped and compared on the falling edge.
   initial begin
      forever begin
         @(negedge wr_clk);
         if (err_overlen === 1'b1) err_seen++;
         if (wr_en === 1'b1) begin
            wr_total++;
            chk("no_write_while_full", {31'd0, full}, 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got %0h with no write expected", wr_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (wr_data !== e) begin
                  errors++;
                  $display("FAIL wr_data: got %0h expected %0h", wr_data, e);
               end
            end
         end
      end
   end

   task automatic push_frame(input int n, input logic [47:0] d, input logic [7:0] csum);
      exp_q.push_back(8'hA5);
      for (int i = 0; i < n && i < MAXL; i++) exp_q.push_back(d[8*i +: 8]);
      exp_q.push_back(csum);
   endtask

   // Offers n beats; called at posedge+1, returns at posedge+1 with in_valid low.
   task automatic send_pkt(input int n, input logic [47:0] d);
      int   i     = 0;
      int   guard = 0;
      logic acc;
      in_valid = 1'b1;
      in_data  = d[7:0];
      in_last  = (n == 1);
      while (i < n) begin
         @(negedge wr_clk);
         acc = in_valid && in_ready;
         @(posedge wr_clk);
         #1;
         if (acc) begin
            i++;
            if (i < n) begin
               in_data = d[8*i +: 8];
               in_last = (i == n - 1);
            end
         end
         guard++;
         if (guard > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: accepted %0d of %0d beats", i, n);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge wr_clk);
      #1;
      chk("drain_pending_writes", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Raises full for 3 cycles right after the second write of the frame.
   task automatic stall_seq(input int base);
      for (int k = 0; k < 50 && wr_total < base + 2; k++) begin
         @(negedge wr_clk);
         #1;
      end
      @(posedge wr_clk);
      #1;
      full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge wr_clk);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_wr_en", {31'd0, wr_en}, 32'd0);
         @(posedge wr_clk);
      end
      #1;
      full = 1'b0;
   endtask

   task automatic do_reset();
      wr_rst   = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      full     = 1'b0;
      repeat (2) @(posedge wr_clk);
      @(negedge wr_clk);
      wr_rst = 1'b0;
      @(posedge wr_clk);
      #1;
   endtask

   initial begin
      int exp_cnt;
      int err0;

      tbl[0] = '{n: 3, d: 48'h0000_0033_2211, exp_csum: 8'h00, exp_trunc: 1'b0, stall: 1'b0};
      tbl[1] = '{n: 3, d: 48'h0000_0033_2211, exp_csum: 8'h00, exp_trunc: 1'b0, stall: 1'b1};
      tbl[2] = '{n: 6, d: 48'h0605_0403_0201, exp_csum: 8'hFB, exp_trunc: 1'b1, stall: 1'b0};
      tbl[3] = '{n: 4, d: 48'h0000_4030_2010, exp_csum: 8'h40, exp_trunc: 1'b0, stall: 1'b0};
      tbl[4] = '{n: 1, d: 48'h0000_0000_007E, exp_csum: 8'h7E, exp_trunc: 1'b0, stall: 1'b0};
      tbl[5] = '{n: 2, d: 48'h0000_0000_55AA, exp_csum: 8'hFF, exp_trunc: 1'b0, stall: 1'b0};

      // Reset state, with in_valid high to show wr_en is held off.
      wr_rst   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h00;
      in_last  = 1'b0;
      full     = 1'b0;
      #2;
      chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      chk("reset_frame_cnt", {28'd0, frame_cnt}, 32'd0);
      chk("reset_err_overlen", {31'd0, err_overlen}, 32'd0);
      do_reset();

      exp_cnt = 0;
      for (int v = 0; v < 6; v++) begin
         err0 = err_seen;
         push_frame(tbl[v].n, tbl[v].d, tbl[v].exp_csum);
         if (tbl[v].stall) begin
            fork
               send_pkt(tbl[v].n, tbl[v].d);
               stall_seq(wr_total);
            join
         end else begin
            send_pkt(tbl[v].n, tbl[v].d);
         end
         wait_drain();
         repeat (2) @(posedge wr_clk);
         #1;
         exp_cnt = (exp_cnt + 1) % 16;
         chk($sformatf("vec%0d_frame_cnt", v), {28'd0, frame_cnt}, exp_cnt);
         chk($sformatf("vec%0d_err_pulses", v), err_seen - err0, {31'd0, tbl[v].exp_trunc});
      end

      // Asynchronous reset in the middle of a payload.
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h11);
      in_valid = 1'b1;
      in_data  = 8'h11;
      in_last  = 1'b0;
      @(posedge wr_clk);
      @(posedge wr_clk);
      #3;
      wr_rst = 1'b1;
      #1;
      chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst_frame_cnt", {28'd0, frame_cnt}, 32'd0);
      chk("midrst_writes_before", exp_q.size(), 32'd0);
      exp_q.delete();
      do_reset();
      push_frame(1, 48'h7E, 8'h7E);
      send_pkt(1, 48'h7E);
      wait_drain();
      repeat (2) @(posedge wr_clk);
      #1;
      chk("post_rst_frame_cnt", {28'd0, frame_cnt}, 32'd1);

      // 17 back-to-back one-beat frames: counter wraps to 1.
      do_reset();
      for (int f = 0; f < 17; f++) begin
         push_frame(1, 48'h7E, 8'h7E);
         send_pkt(1, 48'h7E);
      end
      wait_drain();
      repeat (2) @(posedge wr_clk);
      #1;
      chk("wrap_frame_cnt", {28'd0, frame_cnt}, 32'd1);
      chk("wrap_no_err", err_seen, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_wr_framer.md
Name: fifo_wr_framer

Overview:
- Write-side framing stage that sits directly upstream of the async FIFO.
- Accepts a byte stream with valid/ready/last handshaking and writes framed packets into the FIFO write port: SOF byte, payload bytes, then an XOR checksum byte.
- Honours the FIFO full flag with zero-latency backpressure.
- Runs entirely in the wr_clk domain.

Parameters:
- WIDTH, 8, data width of the input stream and of wr_data.
- MAX_LEN, 64, maximum payload beats per frame (at least 2).
- SOF, 8'hA5, start-of-frame marker written before each payload.
- CNT_W, 16, width of the frame counter.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  payload beat.
- in_last  in  1  marks the final payload beat of a packet.
- full  in  1  FIFO full flag (write domain).
- wr_en  out  1  FIFO write strobe.
- wr_data  out  WIDTH  FIFO write data.
- frame_cnt  out  CNT_W  count of completed frames; wraps.
- err_overlen  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Decided interface: clock wr_clk; reset wr_rst, asynchronous, active-high.
- Reset values:
  - State IDLE.
  - csum = 0, len = 0.
  - frame_cnt = 0, err_overlen = 0.
  - wr_en = 0 and in_ready = 0, because both decode from the state.
- Reset mid-frame abandons the partial frame. Recovering the FIFO contents is the consumer's job.
- wr_en, wr_data and in_ready are combinational from state, registers, in_valid and full. A write lands in the same wr_clk edge the FIFO samples, so no write is ever issued while full = 1.
- FSM states: IDLE, PAYLOAD, CSUM, DROP.
- IDLE:
  - wr_data = SOF; wr_en = in_valid && !full; in_ready = 0.
  - On wr_en: go to PAYLOAD, csum <= 0, len <= 0.
- PAYLOAD:
  - in_ready = !full; wr_en = in_valid && !full; wr_data = in_data.
  - On accept: csum <= csum ^ in_data; len <= len + 1.
  - If in_last: go to CSUM.
  - Else if len == MAX_LEN-1 (this is the MAX_LEN-th beat): go to CSUM, set the trunc flag, and pulse err_overlen next cycle.
- CSUM:
  - wr_data = csum, or ~csum if trunc is set; wr_en = !full; in_ready = 0.
  - On wr_en: frame_cnt <= frame_cnt + 1 (mod 2^CNT_W).
  - Then go to DROP if trunc is set, else IDLE; clear trunc.
- DROP:
  - in_ready = 1 regardless of full; wr_en = 0.
  - Discard beats; on an accepted in_last, go to IDLE.
- in_last on exactly the MAX_LEN-th beat is a normal frame, not a truncation.
- Frame length on the FIFO side = payload + 2. Minimum frame is 3 writes (1-beat payload).
- Backpressure boundaries:
  - full can rise between any two writes of a frame. The FSM holds its state and contents unchanged until full drops.
  - Upstream must hold in_data/in_last while in_valid && !in_ready.
- len width is $clog2(MAX_LEN) bits; len never exceeds MAX_LEN-1.
- Throughput: one FIFO write per cycle while !full. There is a one-cycle turnaround only through DROP.

Decomposition:
- Shared package fifo_pkg:
  - State enum (IDLE, PAYLOAD, CSUM, DROP).
  - Default SOF constant.
  - Function for the checksum fold.
- Sub-module fifo_frame_csum: XOR accumulator with clear/enable/invert-out, instantiated once.
- The FSM, length counter and frame counter live in the top.

Test Plan:
- Reset, then the 3-beat packet 8'h11, 8'h22, 8'h33 (last on 8'h33), full = 0 -> FIFO receives A5, 11, 22, 33, 00 on 5 consecutive cycles; frame_cnt = 1.
- Same packet with full held high for 3 cycles after the 2nd write -> identical byte sequence with no write while full; in_ready = 0 during the stall.
- MAX_LEN = 4 and a 6-beat packet 01..06 -> writes A5, 01, 02, 03, 04, then 8'hFB (~04); err_overlen pulses once; beats 05 and 06 are consumed with no writes; next packet starts cleanly with A5.
- Packet of exactly MAX_LEN = 4 beats with last on the 4th -> normal checksum, no err_overlen, no DROP.
- Assert wr_rst asynchronously mid-PAYLOAD -> wr_en and in_ready drop immediately, frame_cnt = 0; next packet begins with A5.
- Back-to-back 1-beat packets (8'h7E) for 2^CNT_W + 1 frames with CNT_W = 4 -> each frame is A5, 7E, 7E; frame_cnt wraps to 1.
